// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared core sizing constants and types for the PRF read path
package core_types_pkg;
  localparam int PR_COUNT                = 64;
  localparam int LOG_PR_COUNT            = $clog2(PR_COUNT);
  localparam int PRF_BANK_COUNT          = 4;
  localparam int LOG_PRF_BANK_COUNT      = $clog2(PRF_BANK_COUNT);
  localparam int PRF_ROWS                = PR_COUNT / PRF_BANK_COUNT;
  localparam int LOG_PRF_ROWS            = $clog2(PRF_ROWS);
  localparam int PRF_RR_COUNT            = 14;
  localparam int LOG_PRF_RR_COUNT        = $clog2(PRF_RR_COUNT);
  localparam int PRF_READ_PORT_COUNT     = 2;
  localparam int LOG_PRF_READ_PORT_COUNT = $clog2(PRF_READ_PORT_COUNT);
  localparam int XLEN                    = 32;

  typedef logic [LOG_PR_COUNT-1:0]       pr_t;
  typedef logic [LOG_PRF_RR_COUNT-1:0]   rr_idx_t;
  typedef logic [LOG_PRF_ROWS-1:0]       prf_row_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0] prf_bank_t;

  // Requestor indices wrap at PRF_RR_COUNT, not at the power of two.
  function automatic rr_idx_t rr_wrap_inc(input rr_idx_t i);
    return (i == rr_idx_t'(PRF_RR_COUNT - 1)) ? '0 : i + rr_idx_t'(1);
  endfunction
endpackage

// File: rtl/prf_read_arbiter_picker.sv
// rtl/prf_read_arbiter_picker.sv - per-bank round-robin two-port picker with same-PR merging
import core_types_pkg::*;

module prf_bank_rr_picker (
  input  logic [PRF_RR_COUNT-1:0]               cand,
  input  pr_t [PRF_RR_COUNT-1:0]                pr,
  input  rr_idx_t                               ptr,
  output logic [PRF_READ_PORT_COUNT-1:0]        win_valid,
  output rr_idx_t [PRF_READ_PORT_COUNT-1:0]     win_idx,
  output logic [PRF_RR_COUNT-1:0]               ack,
  output logic [PRF_RR_COUNT-1:0]               port_sel,
  output rr_idx_t                               next_ptr
);
  rr_idx_t idx;
  rr_idx_t last;

  always_comb begin
    win_valid = '0;
    win_idx   = '0;
    idx       = ptr;
    for (int k = 0; k < PRF_RR_COUNT; k++) begin
      if (cand[idx]) begin
        if (!win_valid[0]) begin
          win_valid[0] = 1'b1;
          win_idx[0]   = idx;
        end else if (!win_valid[1] && (pr[idx] != pr[win_idx[0]])) begin
          win_valid[1] = 1'b1;
          win_idx[1]   = idx;
        end
      end
      idx = rr_wrap_inc(idx);
    end
  end

  // Any candidate sharing a winner's PR rides along on that winner's port.
  always_comb begin
    ack      = '0;
    port_sel = '0;
    for (int i = 0; i < PRF_RR_COUNT; i++) begin
      port_sel[i] = cand[i] && win_valid[1] && (pr[i] == pr[win_idx[1]]);
      ack[i]      = port_sel[i] || (cand[i] && win_valid[0] && (pr[i] == pr[win_idx[0]]));
    end
    last     = win_valid[1] ? win_idx[1] : win_idx[0];
    next_ptr = win_valid[0] ? rr_wrap_inc(last) : ptr;
  end
endmodule

// File: rtl/prf_read_arbiter.sv
// rtl/prf_read_arbiter.sv - shares banked PRF read ports among requestors and steers read data back
import core_types_pkg::*;

module prf_read_arbiter (
  input  logic                                                     CLK,
  input  logic                                                     RST,
  input  logic [PRF_RR_COUNT-1:0]                                  req_valid_by_rr,
  input  pr_t [PRF_RR_COUNT-1:0]                                   req_pr_by_rr,
  output logic [PRF_RR_COUNT-1:0]                                  req_ack_by_rr,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]       bank_read_en_by_bank_by_port,
  output prf_row_t [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]   bank_read_row_by_bank_by_port,
  input  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][XLEN-1:0] bank_read_data_by_bank_by_port,
  output logic [PRF_RR_COUNT-1:0]                                  resp_valid_by_rr,
  output logic [PRF_RR_COUNT-1:0][XLEN-1:0]                        resp_data_by_rr
);
  rr_idx_t [PRF_BANK_COUNT-1:0]                            ptr;
  rr_idx_t [PRF_BANK_COUNT-1:0]                            next_ptr;
  logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0]             cand;
  logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0]             bank_ack;
  logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0]             bank_port_sel;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]      win_valid;
  rr_idx_t [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]   win_idx;
  prf_bank_t [PRF_RR_COUNT-1:0]                            bank_sel;
  logic [PRF_RR_COUNT-1:0]                                 port_sel;
  logic [PRF_RR_COUNT-1:0]                                 grant_port;

  // Gating candidates with RST keeps every grant, ack and enable low during reset.
  always_comb begin
    cand = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_RR_COUNT; i++) begin
        cand[b][i] = req_valid_by_rr[i] && !RST &&
                     (req_pr_by_rr[i][LOG_PRF_BANK_COUNT-1:0] == prf_bank_t'(b));
      end
    end
  end

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
    prf_bank_rr_picker u_picker (
      .cand      (cand[b]),
      .pr        (req_pr_by_rr),
      .ptr       (ptr[b]),
      .win_valid (win_valid[b]),
      .win_idx   (win_idx[b]),
      .ack       (bank_ack[b]),
      .port_sel  (bank_port_sel[b]),
      .next_ptr  (next_ptr[b])
    );
  end

  always_comb begin
    req_ack_by_rr = '0;
    grant_port    = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      req_ack_by_rr = req_ack_by_rr | bank_ack[b];
      grant_port    = grant_port | bank_port_sel[b];
    end
  end

  always_comb begin
    bank_read_en_by_bank_by_port  = win_valid;
    bank_read_row_by_bank_by_port = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int p = 0; p < PRF_READ_PORT_COUNT; p++) begin
        if (win_valid[b][p]) begin
          bank_read_row_by_bank_by_port[b][p] =
            req_pr_by_rr[win_idx[b][p]][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
        end
      end
    end
  end

  always_comb begin
    resp_data_by_rr = '0;
    for (int i = 0; i < PRF_RR_COUNT; i++) begin
      resp_data_by_rr[i] = bank_read_data_by_bank_by_port[bank_sel[i]][port_sel[i]];
    end
  end

  // Steering only moves on an ack so idle requestors keep a known, in-range select.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr              <= '0;
      resp_valid_by_rr <= '0;
      bank_sel         <= '0;
      port_sel         <= '0;
    end else begin
      ptr              <= next_ptr;
      resp_valid_by_rr <= req_ack_by_rr;
      for (int i = 0; i < PRF_RR_COUNT; i++) begin
        if (req_ack_by_rr[i]) begin
          bank_sel[i] <= req_pr_by_rr[i][LOG_PRF_BANK_COUNT-1:0];
          port_sel[i] <= grant_port[i];
        end
      end
    end
  end
endmodule
